spmv_vector_gather: RTL and testbench
=====================================

Name: spmv_vector_gather

Overview:
- Upstream feeder for one vector RAM virtual port in the SpMV datapath.
- Consumes the CSR nonzero stream (column index, matrix value, row-last flag) and issues random reads of x[col] to its vector RAM port.
- Pairs each returned x value, in order, with its matrix value and emits (a_ij, x_j, last) to the multiply/accumulate stage.
- Credit-limits outstanding reads so internal buffers can never overflow and the vector RAM read return never needs to stall.

Parameters:
- DATA_WIDTH, 32, width of matrix values and vector data.
- ADDR_WIDTH, 16, width of vector (column) index.
- MAX_OUTSTANDING, 8, max reads issued but not yet consumed at the output; power of 2, ≥2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- s_valid  in  1  nonzero stream valid.
- s_ready  out  1  nonzero stream ready.
- s_col  in  ADDR_WIDTH  column index.
- s_val  in  DATA_WIDTH  matrix value.
- s_last  in  1  last nonzero of a row.
- vr_arvalid  out  1  vector RAM read request valid.
- vr_raddr  out  ADDR_WIDTH  vector RAM read address.
- vr_arready  in  1  vector RAM port can accept a request.
- vr_rvalid  in  1  vector RAM read data valid.
- vr_rdata  in  DATA_WIDTH  vector RAM read data.
- vr_rready  out  1  read-data ready.
- m_valid  out  1  product-operand valid.
- m_ready  in  1  downstream ready.
- m_mat  out  DATA_WIDTH  matrix value.
- m_vec  out  DATA_WIDTH  x[col].
- m_last  out  1  row-last flag.
- drain  in  1  stop accepting input and empty the pipe.
- idle  out  1  nothing outstanding or buffered.
- err_unexpected  out  1  sticky: read data arrived with zero reads outstanding.

Behaviour:
- Reset: s_ready=0, vr_arvalid=0, vr_rready=0, m_valid=0, idle=1, err_unexpected=0, credits=MAX_OUTSTANDING, both FIFOs empty, state=RUN.
- Credit counter range 0..MAX_OUTSTANDING:
  - decrement on request accept (vr_arvalid && vr_arready);
  - increment on output pop (m_valid && m_ready);
  - both in one cycle: unchanged.
- Request path is combinational pass-through:
  - vr_arvalid = s_valid && credits>0 && state==RUN;
  - vr_raddr = s_col;
  - s_ready = vr_arready && credits>0 && state==RUN.
- On accept, push {s_val, s_last} to the side FIFO (depth MAX_OUTSTANDING). Its full flag is unreachable by construction; add an assertion.
- vr_rready = 1 whenever out of reset. Every vr_rvalid pushes vr_rdata to the response FIFO (depth MAX_OUTSTANDING).
  - Response FIFO cannot overflow because credits cover buffered and in-flight entries.
  - vr_rvalid while side FIFO occupancy equals response FIFO occupancy sets err_unexpected; the data is dropped.
- Output (vector RAM port is in-order per port):
  - m_valid = both FIFO heads valid;
  - m_mat/m_last from side head, m_vec from response head;
  - pop both on m_valid && m_ready;
  - outputs held stable while m_valid && !m_ready.
- Latency: request accept → m_valid is RAM latency + 1 cycle (response FIFO registered, read latency 0).
- Full throughput of 1 nonzero/cycle is sustained when RAM latency + 1 < MAX_OUTSTANDING.
- State machine:
  - RUN → DRAIN on drain=1.
  - DRAIN: s_ready=0, vr_arvalid=0.
  - DRAIN → RUN when drain=0 and idle=1.
  - Deasserting drain before idle keeps DRAIN.
- idle = credits==MAX_OUTSTANDING && both FIFOs empty.
- Async reset mid-operation: discards all in-flight state. A read returning after reset release counts as unexpected.

Optional Feature:
- Macro: SPMV_GATHER_ZERO_SKIP_EN.
- With it:
  - s_val==0 consumes a credit and pushes a side entry tagged skip, but issues no read (vr_arvalid=0 and vr_arready ignored for that beat).
  - A skip entry at the side head outputs m_vec=0 without needing the response FIFO; it is popped alone.
  - Ordering is preserved.
- Without it: zero values are read like any other nonzero. The side FIFO has no skip bit.

Decomposition:
- Package spmv_gather_pkg holds:
  - state enum (RUN, DRAIN);
  - side-entry struct {val, last[, skip]};
  - CREDIT_WIDTH = $clog2(MAX_OUTSTANDING+1) helper.
- Both FIFOs instantiate the existing basic_sync_fifo (READ_LATENCY 0). No new sub-module.

Test Plan:
- Stream cols 0..15, val=i+1, last on every 4th nonzero; RAM latency 1, m_ready=1 → 16 outputs in order, m_vec=x[col], 1/cycle after a 2-cycle fill, m_last on outputs 3, 7, 11, 15.
- m_ready=0 for 20 cycles with continuous input, MAX_OUTSTANDING=8 → exactly 8 reads issued, then s_ready=0; release → all data intact, no err.
- vr_arready toggling 1,0,1,0 → s_ready follows it; no duplicate or lost requests; order preserved.
- Assert drain mid-stream with 5 outstanding → s_ready=0 the next cycle; idle=1 after the 5 outputs pop; drain low → RUN.
- Inject vr_rvalid with nothing outstanding → err_unexpected=1 and stays until rst_n=0; FIFOs unchanged.
- With SPMV_GATHER_ZERO_SKIP_EN, vals {3,0,5} → 2 reads issued; outputs (3,x),(0,0),(5,x) in order.

Source files
------------

// File: rtl/spmv_gather_pkg.sv
// Shared types for the SpMV vector gather: FSM states, side-FIFO entry, credit sizing.
// SPMV_GATHER_ZERO_SKIP_EN adds a skip tag to the side entry.
package spmv_gather_pkg;

    localparam int SIDE_DATA_WIDTH = 32;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    typedef struct packed {
        logic [SIDE_DATA_WIDTH-1:0] val;
        logic                       last;
`ifdef SPMV_GATHER_ZERO_SKIP_EN
        logic                       skip;
`endif
    } side_entry_t;

    function automatic int credit_width(input int max_outstanding);
        return $clog2(max_outstanding + 1);
    endfunction

endpackage

// File: rtl/basic_sync_fifo.sv
// Synchronous FIFO with occupancy count; READ_LATENCY 0 shows the head combinationally.
// Push while full and pop while empty are ignored.
module basic_sync_fifo #(
    parameter  int WIDTH        = 8,
    parameter  int DEPTH        = 8,
    parameter  int READ_LATENCY = 0,
    localparam int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: nothing reads it before a push.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

    generate
        if (READ_LATENCY == 0) begin : g_comb_read
            assign rdata = mem_q[rptr_q];
        end else begin : g_reg_read
            logic [WIDTH-1:0] rdata_q;
            always_ff @(posedge clk) rdata_q <= mem_q[rptr_q];
            assign rdata = rdata_q;
        end
    endgenerate

endmodule

// File: rtl/spmv_vector_gather.sv
// Credit-limited gather of x[col] for the CSR nonzero stream, pairing returns in order with a_ij.
// SPMV_GATHER_ZERO_SKIP_EN: zero matrix values bypass the vector RAM and emit x=0.
module spmv_vector_gather
    import spmv_gather_pkg::*;
#(
    parameter int DATA_WIDTH      = SIDE_DATA_WIDTH,
    parameter int ADDR_WIDTH      = 16,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [ADDR_WIDTH-1:0] s_col,
    input  logic [DATA_WIDTH-1:0] s_val,
    input  logic                  s_last,
    output logic                  vr_arvalid,
    output logic [ADDR_WIDTH-1:0] vr_raddr,
    input  logic                  vr_arready,
    input  logic                  vr_rvalid,
    input  logic [DATA_WIDTH-1:0] vr_rdata,
    output logic                  vr_rready,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_mat,
    output logic [DATA_WIDTH-1:0] m_vec,
    output logic                  m_last,
    input  logic                  drain,
    output logic                  idle,
    output logic                  err_unexpected
);

    localparam int CREDIT_WIDTH = credit_width(MAX_OUTSTANDING);
    localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(MAX_OUTSTANDING);
    localparam int SIDE_W = $bits(side_entry_t);

    state_e                  state_q, state_d;
    logic [CREDIT_WIDTH-1:0] credits_q, credits_d;
    logic                    active_q;
    logic                    err_q, err_d;

    logic                    accepting;
    logic                    side_push, side_pop, side_full, side_empty;
    logic [CREDIT_WIDTH-1:0] side_cnt;
    side_entry_t             side_in, side_out;
    logic                    resp_push, resp_pop, resp_full, resp_empty;
    logic [CREDIT_WIDTH-1:0] resp_cnt;
    logic [DATA_WIDTH-1:0]   resp_out;
    logic                    rd_fire, rd_pending, head_skip, m_fire;

    // active_q holds the handshakes low for the first cycle after reset release.
    assign accepting = active_q && (credits_q != '0) && (state_q == ST_RUN);
    assign vr_raddr  = s_col;
    assign vr_rready = active_q;
    assign side_push = s_valid && s_ready;

`ifdef SPMV_GATHER_ZERO_SKIP_EN
    logic                    s_skip, ar_fire;
    logic [CREDIT_WIDTH-1:0] rd_pend_q, rd_pend_d;

    assign s_skip       = (s_val == '0);
    assign vr_arvalid   = s_valid && accepting && !s_skip;
    assign s_ready      = accepting && (s_skip || vr_arready);
    assign side_in.skip = s_skip;
    assign head_skip    = side_out.skip;
    assign ar_fire      = vr_arvalid && vr_arready;
    // Skip entries break the side/response occupancy relation, so reads are counted directly.
    assign rd_pending   = (rd_pend_q != '0);

    always_comb begin
        unique case ({ar_fire, resp_push})
            2'b10:   rd_pend_d = rd_pend_q + 1'b1;
            2'b01:   rd_pend_d = rd_pend_q - 1'b1;
            default: rd_pend_d = rd_pend_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_pend_q <= '0;
        else        rd_pend_q <= rd_pend_d;
    end
`else
    assign vr_arvalid = s_valid && accepting;
    assign s_ready    = accepting && vr_arready;
    assign head_skip  = 1'b0;
    // Side entries without a response yet are exactly the reads still in flight.
    assign rd_pending = (side_cnt != resp_cnt);
`endif

    assign side_in.val  = s_val;
    assign side_in.last = s_last;

    assign rd_fire   = vr_rvalid && vr_rready;
    assign resp_push = rd_fire && rd_pending;

    assign m_valid  = !side_empty && (head_skip || !resp_empty);
    assign m_mat    = side_out.val;
    assign m_last   = side_out.last;
    assign m_vec    = head_skip ? '0 : resp_out;
    assign m_fire   = m_valid && m_ready;
    assign side_pop = m_fire;
    assign resp_pop = m_fire && !head_skip;

    assign idle           = (credits_q == CREDIT_MAX) && (side_cnt == '0) && (resp_cnt == '0);
    assign err_unexpected = err_q;

    basic_sync_fifo #(
        .WIDTH(SIDE_W), .DEPTH(MAX_OUTSTANDING), .READ_LATENCY(0)
    ) u_side_fifo (
        .clk(clk), .rst_n(rst_n), .push(side_push), .wdata(side_in), .pop(side_pop),
        .rdata(side_out), .full(side_full), .empty(side_empty), .count(side_cnt)
    );

    basic_sync_fifo #(
        .WIDTH(DATA_WIDTH), .DEPTH(MAX_OUTSTANDING), .READ_LATENCY(0)
    ) u_resp_fifo (
        .clk(clk), .rst_n(rst_n), .push(resp_push), .wdata(vr_rdata), .pop(resp_pop),
        .rdata(resp_out), .full(resp_full), .empty(resp_empty), .count(resp_cnt)
    );

    always_comb begin
        credits_d = credits_q;
        unique case ({side_push, m_fire})
            2'b10:   credits_d = credits_q - 1'b1;
            2'b01:   credits_d = credits_q + 1'b1;
            default: credits_d = credits_q;
        endcase
    end

    always_comb begin
        err_d = err_q | (rd_fire && !rd_pending);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:   if (drain) state_d = ST_DRAIN;
            ST_DRAIN: if (!drain && idle) state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            credits_q <= CREDIT_MAX;
            active_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            credits_q <= credits_d;
            active_q  <= 1'b1;
            err_q     <= err_d;
        end
    end

    // Credits bound both FIFOs' occupancy to MAX_OUTSTANDING.
    a_side_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) side_push |-> !side_full);
    a_resp_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) resp_push |-> !resp_full);

endmodule

// File: tb/tb_spmv_vector_gather.sv
// Bench for spmv_vector_gather: table-driven stream, corner sequences and a random run
// against an in-order scoreboard; covers SPMV_GATHER_ZERO_SKIP_EN when defined.
module tb_spmv_vector_gather;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int MO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0, s_ready, s_last = 1'b0;
    logic [AW-1:0] s_col = '0;
    logic [DW-1:0] s_val = '0;
    logic          vr_arvalid, vr_arready = 1'b1, vr_rvalid = 1'b0, vr_rready;
    logic [AW-1:0] vr_raddr;
    logic [DW-1:0] vr_rdata = '0;
    logic          m_valid, m_ready = 1'b1, m_last;
    logic [DW-1:0] m_mat, m_vec;
    logic          drain = 1'b0, idle, err_unexpected;

    always #5 clk = ~clk;

    spmv_vector_gather #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_col(s_col), .s_val(s_val), .s_last(s_last),
        .vr_arvalid(vr_arvalid), .vr_raddr(vr_raddr), .vr_arready(vr_arready),
        .vr_rvalid(vr_rvalid), .vr_rdata(vr_rdata), .vr_rready(vr_rready),
        .m_valid(m_valid), .m_ready(m_ready), .m_mat(m_mat), .m_vec(m_vec), .m_last(m_last),
        .drain(drain), .idle(idle), .err_unexpected(err_unexpected)
    );

    typedef struct { logic [AW-1:0] col; logic [DW-1:0] val; logic last; } beat_t;
    typedef struct { logic [DW-1:0] mat; logic [DW-1:0] vec; logic last; } out_t;
    typedef struct {
        logic [AW-1:0] col; logic [DW-1:0] val; logic last;
        logic [DW-1:0] exp_vec; logic exp_last;
    } vec_t;

    beat_t stim_q[$];
    out_t  sb_q[$];
    out_t  out_log[$];
    int    acc_cyc_q[$];
    int    fire_cyc_q[$];

    int total = 0, bad = 0;
    int cyc = 0, acc_cnt = 0, fire_cnt = 0, rd_cnt = 0, outst = 0;
    logic acc_flag = 1'b0, req_v = 1'b0, hold_v = 1'b0, inj = 1'b0;
    logic [AW-1:0] req_a = '0;
    out_t hold_o;
    int lat = 1, ar_mode = 0, mr_mode = 0;
    bit gap_en = 0;
    logic          pipe_v [4] = '{default: 1'b0};
    logic [AW-1:0] pipe_a [4] = '{default: '0};

    function automatic logic [DW-1:0] xval(input logic [AW-1:0] a);
        return {a ^ 16'hC3A5, a};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: handshakes are stable by the falling edge.
    always @(negedge clk) begin
        out_t e;
        logic [DW-1:0] ev;
        if (!rst_n) begin
            acc_flag = 1'b0; req_v = 1'b0; hold_v = 1'b0; outst = 0;
        end else begin
            if (outst == MO) check("credit_stall", 64'(s_ready), 64'(0));
            acc_flag = s_valid && s_ready;
            req_v    = vr_arvalid && vr_arready;
            req_a    = vr_raddr;
            if (req_v) rd_cnt++;
            if (acc_flag) begin
`ifdef SPMV_GATHER_ZERO_SKIP_EN
                ev = (s_val == '0) ? '0 : xval(s_col);
`else
                ev = xval(s_col);
`endif
                acc_cnt++;
                outst++;
                acc_cyc_q.push_back(cyc);
                sb_q.push_back('{mat: s_val, vec: ev, last: s_last});
            end
            if (hold_v) begin
                check("hold_valid", 64'(m_valid), 64'(1));
                check("hold_mat", 64'(m_mat), 64'(hold_o.mat));
                check("hold_vec", 64'(m_vec), 64'(hold_o.vec));
            end
            if (m_valid && m_ready) begin
                fire_cnt++;
                outst--;
                fire_cyc_q.push_back(cyc);
                out_log.push_back('{mat: m_mat, vec: m_vec, last: m_last});
                if (sb_q.size() == 0) check("sb_underflow", 64'(1), 64'(0));
                else begin
                    e = sb_q.pop_front();
                    check("out_mat", 64'(m_mat), 64'(e.mat));
                    check("out_vec", 64'(m_vec), 64'(e.vec));
                    check("out_last", 64'(m_last), 64'(e.last));
                end
            end
            hold_v = m_valid && !m_ready;
            hold_o = '{mat: m_mat, vec: m_vec, last: m_last};
        end
    end

    // Stream driver and downstream ready.
    always @(posedge clk) begin
        #1;
        if (s_valid && acc_flag && stim_q.size() > 0) void'(stim_q.pop_front());
        if (stim_q.size() > 0 && !(gap_en && $urandom_range(3) == 0)) begin
            s_valid = 1'b1;
            s_col   = stim_q[0].col;
            s_val   = stim_q[0].val;
            s_last  = stim_q[0].last;
        end else begin
            s_valid = 1'b0;
        end
        m_ready = (mr_mode == 0) ? 1'b1 : (mr_mode == 1) ? 1'b0 : 1'($urandom_range(1));
    end

    // Vector RAM model: fixed latency delay line, independent of the DUT's reset.
    always @(posedge clk) begin
        #1;
        for (int i = 3; i > 0; i--) begin
            pipe_v[i] = pipe_v[i-1];
            pipe_a[i] = pipe_a[i-1];
        end
        pipe_v[0]  = req_v;
        pipe_a[0]  = req_a;
        vr_rvalid  = pipe_v[lat-1] || inj;
        vr_rdata   = inj ? 32'hDEAD_BEEF : xval(pipe_a[lat-1]);
        vr_arready = (ar_mode == 0) ? 1'b1 : (ar_mode == 1) ? ~vr_arready : 1'($urandom_range(1));
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            step(1);
            if (idle && !s_valid && stim_q.size() == 0 && sb_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        check(name, 64'(ok), 64'(1));
    endtask

    task automatic push_beat(input logic [AW-1:0] c, input logic [DW-1:0] v, input logic l);
        stim_q.push_back('{col: c, val: v, last: l});
    endtask

    vec_t tv[16];

    initial begin
        int a0, f0, r0, n0;
        bit ok;

        step(3);
        check("rst_s_ready", 64'(s_ready), 64'(0));
        check("rst_arvalid", 64'(vr_arvalid), 64'(0));
        check("rst_rready", 64'(vr_rready), 64'(0));
        check("rst_m_valid", 64'(m_valid), 64'(0));
        check("rst_idle", 64'(idle), 64'(1));
        check("rst_err", 64'(err_unexpected), 64'(0));
        rst_n = 1'b1;
        step(2);
        check("run_rready", 64'(vr_rready), 64'(1));

        // Table-driven stream, latency 1, free-flowing output.
        for (int i = 0; i < 16; i++) begin
            tv[i] = '{col: AW'(i), val: DW'(i + 1), last: (i % 4 == 3),
                      exp_vec: xval(AW'(i)), exp_last: (i % 4 == 3)};
        end
        out_log.delete(); acc_cyc_q.delete(); fire_cyc_q.delete();
        for (int i = 0; i < 16; i++) push_beat(tv[i].col, tv[i].val, tv[i].last);
        wait_idle("t1_done", 100);
        check("t1_count", 64'(out_log.size()), 64'(16));
        for (int i = 0; i < 16 && i < out_log.size(); i++) begin
            check("t1_mat", 64'(out_log[i].mat), 64'(tv[i].val));
            check("t1_vec", 64'(out_log[i].vec), 64'(tv[i].exp_vec));
            check("t1_last", 64'(out_log[i].last), 64'(tv[i].exp_last));
        end
        if (fire_cyc_q.size() == 16 && acc_cyc_q.size() == 16) begin
            check("t1_fill_latency", 64'(fire_cyc_q[0] - acc_cyc_q[0]), 64'(2));
            check("t1_throughput", 64'(fire_cyc_q[15] - fire_cyc_q[0]), 64'(15));
        end

        // arready toggling: s_ready tracks it, no lost or duplicate reads.
        ar_mode = 1;
        r0 = rd_cnt;
        for (int i = 0; i < 12; i++) push_beat(AW'($urandom), DW'($urandom), 1'($urandom_range(1)));
        for (int i = 0; i < 12; i++) begin
            step(1);
            check("t3_follow", 64'(s_ready), 64'(vr_arready));
        end
        wait_idle("t3_done", 200);
        check("t3_reads", 64'(rd_cnt - r0), 64'(12));
        ar_mode = 0;

        // Output stalled with continuous input: credits cap issued reads.
        mr_mode = 1;
        a0 = acc_cnt;
        for (int i = 0; i < 30; i++) push_beat(AW'(100 + i), DW'($urandom), 1'(i % 3 == 2));
        step(20);
        check("t2_reads", 64'(acc_cnt - a0), 64'(MO));
        check("t2_s_ready", 64'(s_ready), 64'(0));
        check("t2_arvalid", 64'(vr_arvalid), 64'(0));
        mr_mode = 0;
        wait_idle("t2_done", 300);
        check("t2_err", 64'(err_unexpected), 64'(0));

        // Drain with 5 outstanding.
        mr_mode = 1;
        a0 = acc_cnt; f0 = fire_cnt;
        for (int i = 0; i < 5; i++) push_beat(AW'(200 + i), DW'(i + 7), 1'(i == 4));
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (acc_cnt - a0 == 5) begin ok = 1; break; end
        end
        check("t4_issue", 64'(ok), 64'(1));
        drain = 1'b1;
        step(1);
        check("t4_s_ready", 64'(s_ready), 64'(0));
        check("t4_busy", 64'(idle), 64'(0));
        for (int i = 0; i < 3; i++) push_beat(AW'(300 + i), DW'(i + 40), 1'b1);
        step(3);
        check("t4_arvalid", 64'(vr_arvalid), 64'(0));
        check("t4_held", 64'(acc_cnt - a0), 64'(5));
        mr_mode = 0;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (idle) begin ok = 1; break; end
        end
        check("t4_idle", 64'(ok), 64'(1));
        check("t4_pops", 64'(fire_cnt - f0), 64'(5));
        step(2);
        check("t4_stay_drain", 64'(s_ready), 64'(0));
        drain = 1'b0;
        wait_idle("t4_resume", 100);
        check("t4_total", 64'(fire_cnt - f0), 64'(8));

        // Random stimulus at two RAM latencies.
        for (int ph = 0; ph < 2; ph++) begin
            lat = (ph == 0) ? 1 : 3;
            gap_en = 1; mr_mode = 2; ar_mode = 2;
            f0 = fire_cnt;
            for (int i = 0; i < 150; i++) begin
`ifdef SPMV_GATHER_ZERO_SKIP_EN
                push_beat(AW'($urandom), ($urandom_range(3) == 0) ? '0 : DW'($urandom),
                          1'($urandom_range(1)));
`else
                push_beat(AW'($urandom), DW'($urandom), 1'($urandom_range(1)));
`endif
            end
            wait_idle("rand_done", 3000);
            check("rand_count", 64'(fire_cnt - f0), 64'(150));
            gap_en = 0; mr_mode = 0; ar_mode = 0;
            step(4);
        end
        check("rand_err", 64'(err_unexpected), 64'(0));
        lat = 1;

`ifdef SPMV_GATHER_ZERO_SKIP_EN
        r0 = rd_cnt; n0 = out_log.size();
        push_beat(16'd11, 32'd3, 1'b0);
        push_beat(16'd12, 32'd0, 1'b0);
        push_beat(16'd13, 32'd5, 1'b1);
        wait_idle("skip_done", 100);
        check("skip_reads", 64'(rd_cnt - r0), 64'(2));
        if (out_log.size() == n0 + 3) begin
            check("skip_o0", {out_log[n0].mat, out_log[n0].vec}, {32'd3, xval(16'd11)});
            check("skip_o1", {out_log[n0+1].mat, out_log[n0+1].vec}, 64'd0);
            check("skip_o2", {out_log[n0+2].mat, out_log[n0+2].vec}, {32'd5, xval(16'd13)});
        end else check("skip_count", 64'(out_log.size() - n0), 64'(3));
`endif

        // Reset with reads in flight: late returns count as unexpected.
        lat = 3; mr_mode = 1;
        step(4);
        a0 = acc_cnt;
        for (int i = 0; i < 4; i++) push_beat(AW'(400 + i), DW'(i + 1), 1'b0);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (acc_cnt - a0 == 4) begin ok = 1; break; end
        end
        check("t6_issue", 64'(ok), 64'(1));
        step(1);
        rst_n = 1'b0;
        stim_q.delete();
        step(1);
        check("t6_rst_idle", 64'(idle), 64'(1));
        check("t6_rst_m_valid", 64'(m_valid), 64'(0));
        sb_q.delete();
        rst_n = 1'b1;
        step(6);
        check("t6_err", 64'(err_unexpected), 64'(1));
        check("t6_dropped", 64'(idle), 64'(1));
        check("t6_no_out", 64'(m_valid), 64'(0));
        mr_mode = 0; lat = 1;

        // Clean reset, then inject a stray read return.
        rst_n = 1'b0;
        step(1);
        check("t5_rst_err", 64'(err_unexpected), 64'(0));
        rst_n = 1'b1;
        step(3);
        inj = 1'b1;
        step(1);
        inj = 1'b0;
        step(1);
        check("t5_err", 64'(err_unexpected), 64'(1));
        check("t5_idle", 64'(idle), 64'(1));
        check("t5_m_valid", 64'(m_valid), 64'(0));
        step(5);
        check("t5_sticky", 64'(err_unexpected), 64'(1));
        rst_n = 1'b0;
        step(1);
        check("t5_clear", 64'(err_unexpected), 64'(0));
        check("t5_rst_s_ready", 64'(s_ready), 64'(0));
        check("t5_rst_rready", 64'(vr_rready), 64'(0));
        check("t5_rst_idle", 64'(idle), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
